silent_step_applier: RTL and testbench
======================================

Name: silent_step_applier

Overview:
- Consumer end of the silencer step-rate stream.
- Per transducer, accepts an 8-bit intensity/phase target plus the 16-bit 8.8 fixed-point update rates produced for that transducer.
- Advances a stored per-transducer 8.8 current value toward its target by at most the rate, then emits the 8-bit silenced drive values in transducer order.
- Sits between the step-rate calculation and the per-transducer PWM/phase drive.

Parameters:
- DEPTH, 249: transducers per frame; index range 0..DEPTH-1; must be ≤ 256.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- DIN_VALID  in  1  target/rate beat valid
- INTENSITY  in  8  intensity target for current index
- PHASE  in  8  phase target for current index
- UPDATE_RATE_INTENSITY  in  16  max intensity step, 8.8 fixed point
- UPDATE_RATE_PHASE  in  16  max phase step, 8.8 fixed point
- INTENSITY_OUT  out  8  silenced intensity
- PHASE_OUT  out  8  silenced phase
- DOUT_VALID  out  1  output beat valid
- BUSY  out  1  high while state memory initialises

Behaviour:
- Reset values: INTENSITY_OUT=0, PHASE_OUT=0, DOUT_VALID=0, BUSY=1, index counter=0, state=INIT.
- State memory: 256 x 32 bits, holding {cur_i[15:0], cur_p[15:0]}. Not reset directly.
- INIT state:
  - Writes 0 to addresses 0..DEPTH-1, one per cycle; BUSY=1.
  - DIN_VALID is ignored and produces no output.
  - After address DEPTH-1 is written, moves to RUN and BUSY drops on the next cycle.
  - INIT lasts exactly DEPTH cycles after RST_N deassertion.
- RUN state:
  - Each DIN_VALID beat is processed at the index counter value, then the counter increments. Counter wraps DEPTH-1 → 0.
  - Gaps between beats are allowed; the counter holds during gaps.
- Pipeline, fixed latency 3 cycles (DIN_VALID at cycle n gives DOUT_VALID at n+3):
  - S1: registered memory read; the inputs are registered alongside.
  - S2: compute.
  - S3: memory write-back and output register update.
- Read/write hazard:
  - A write-back to index k overlaps the read of index k only when DEPTH ≤ 2.
  - S1 must forward the in-flight S2/S3 result on an address match, so back-to-back frames are correct for any DEPTH ≥ 1.
- Intensity arithmetic (16-bit unsigned), with tgt={INTENSITY,8'h00} and r=UPDATE_RATE_INTENSITY:
  - cur<tgt: new = (tgt-cur ≤ r) ? tgt : cur+r.
  - cur>tgt: new = (cur-tgt ≤ r) ? tgt : cur-r.
  - Equal: hold.
  - No overflow or underflow is possible.
- Phase arithmetic (circular, mod 2^16), with tgt={PHASE,8'h00}, d=(tgt-cur) mod 2^16, r=UPDATE_RATE_PHASE:
  - d=0: hold.
  - 0<d≤0x8000 (forward; the tie goes forward): new = (d ≤ r) ? tgt : cur+r mod 2^16.
  - d>0x8000 (backward): e=2^16-d; new = (e ≤ r) ? tgt : cur-r mod 2^16.
- r=0: value holds.
- r ≥ distance: the value lands exactly on the target, never overshoots.
- Outputs: INTENSITY_OUT=new_i[15:8], PHASE_OUT=new_p[15:8] (truncation).
- DOUT_VALID is a single-cycle pulse per processed beat.
- Asynchronous reset mid-operation:
  - All registers and the pipeline are cleared immediately; in-flight beats are discarded.
  - INIT re-runs, so every current value restarts from 0.

Optional Feature:
- Macro: SILENT_FORCE_EN.
- Defined:
  - Adds input FORCE (1 bit), sampled with DIN_VALID.
  - When FORCE=1 for a beat, new_i=tgt_i and new_p=tgt_p regardless of rate. Used for immediate, non-silenced updates.
  - Latency is unchanged.
- Undefined: no FORCE port; behaviour is rate-limited only.

Test Plan:
- Reset release, DIN_VALID held high → BUSY high for DEPTH cycles (249), no DOUT_VALID during INIT; the first output appears 3 cycles after the first accepted beat.
- DEPTH=249, all INTENSITY=0xFF, rate_i=0x0100, repeated frames → INTENSITY_OUT goes 1,2,…,255 on successive frames and then stays at 255; no overshoot.
- Phase current 0x0A00, PHASE=0xF0, rate_p=0x0800:
  - d=0xE600 → backward; output 0x02, then 0xFA, then 0xF2, then 0xF0 (final step clamped to target), then holds.
- Phase current 0, PHASE=0x80, rate_p=0x4000 → tie goes forward: outputs 0x40, then 0x80.
- Rate 0x0000 with a changed target → outputs unchanged across 3 frames.
- RST_N pulsed low mid-frame → DOUT_VALID stops within the same cycle, INIT re-runs, the next frame starts from index 0 with current=0.
- SILENT_FORCE_EN defined, FORCE=1, INTENSITY=0xC8, rate=1 → INTENSITY_OUT=0xC8 on the first output.

Source files
------------

// File: rtl/silent_step_if.sv
// silent_step_if: target/rate beat stream into the silencer applier and the
// silenced drive stream out of it.
//   master : producer side (drives beats, observes outputs and BUSY)
//   slave  : silent_step_applier side
// Optional macro SILENT_FORCE_EN adds FORCE, sampled together with DIN_VALID.
interface silent_step_if;
    logic        DIN_VALID;
    logic [7:0]  INTENSITY;
    logic [7:0]  PHASE;
    logic [15:0] UPDATE_RATE_INTENSITY;
    logic [15:0] UPDATE_RATE_PHASE;
`ifdef SILENT_FORCE_EN
    logic        FORCE;
`endif
    logic [7:0]  INTENSITY_OUT;
    logic [7:0]  PHASE_OUT;
    logic        DOUT_VALID;
    logic        BUSY;

    modport master (
`ifdef SILENT_FORCE_EN
        output FORCE,
`endif
        output DIN_VALID, INTENSITY, PHASE, UPDATE_RATE_INTENSITY, UPDATE_RATE_PHASE,
        input  INTENSITY_OUT, PHASE_OUT, DOUT_VALID, BUSY
    );

    modport slave (
`ifdef SILENT_FORCE_EN
        input  FORCE,
`endif
        input  DIN_VALID, INTENSITY, PHASE, UPDATE_RATE_INTENSITY, UPDATE_RATE_PHASE,
        output INTENSITY_OUT, PHASE_OUT, DOUT_VALID, BUSY
    );
endinterface

// File: rtl/silent_step_applier.sv
// silent_step_applier: moves each transducer's stored 8.8 intensity/phase
// toward its 8-bit target by at most the supplied rate and emits the 8-bit
// silenced values in transducer order. Fixed 3-cycle latency.
// Ports:
//   CLK    system clock
//   RST_N  asynchronous active-low reset
//   bus    silent_step_if.slave (beats in, silenced drive out, BUSY)
// Optional macro SILENT_FORCE_EN: FORCE=1 on a beat jumps straight to target.
module silent_step_applier #(
    parameter int DEPTH = 249
) (
    input  logic          CLK,
    input  logic          RST_N,
    silent_step_if.slave  bus
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [7:0] LAST    = 8'(DEPTH - 1);

    logic [0:0]  r_state;
    logic [7:0]  r_init_addr;
    logic [7:0]  r_idx;
    logic [31:0] r_mem [256];          // {cur_i, cur_p}
    logic [3:1]  r_vld_pipe;           // [1]=S1, [2]=S2, [3]=output

    logic [7:0]  r_s1_idx;
    logic [31:0] r_s1_cur;
    logic [7:0]  r_s1_tgt_i, r_s1_tgt_p;
    logic [15:0] r_s1_rate_i, r_s1_rate_p;
    logic        r_s1_force;
    logic [7:0]  r_s2_idx;
    logic [31:0] r_s2_new;
    logic [7:0]  r_int_out, r_ph_out;

    logic        w_accept;
    logic        w_force;
    logic [31:0] w_rd;
    logic [15:0] w_cur_i, w_cur_p, w_tgt_i, w_tgt_p;
    logic [15:0] w_up_i, w_dn_i, w_fwd_p, w_bwd_p;
    logic [15:0] w_new_i, w_new_p;
    logic [31:0] w_new;

    assign w_accept = bus.DIN_VALID && (r_state == ST_RUN);

`ifdef SILENT_FORCE_EN
    assign w_force = bus.FORCE;
`else
    assign w_force = 1'b0;
`endif

    // Read with bypass: the beat now in S1 (not yet written) wins over the one
    // in S2 (being written this edge); only reachable when DEPTH <= 2.
    always_comb begin
        w_rd = r_mem[r_idx];
        if (r_vld_pipe[2] && (r_s2_idx == r_idx)) w_rd = r_s2_new;
        if (r_vld_pipe[1] && (r_s1_idx == r_idx)) w_rd = w_new;
    end

    assign w_cur_i = r_s1_cur[31:16];
    assign w_cur_p = r_s1_cur[15:0];
    assign w_tgt_i = {r_s1_tgt_i, 8'h00};
    assign w_tgt_p = {r_s1_tgt_p, 8'h00};
    assign w_up_i  = w_tgt_i - w_cur_i;
    assign w_dn_i  = w_cur_i - w_tgt_i;
    assign w_fwd_p = w_tgt_p - w_cur_p;   // forward distance mod 2^16
    assign w_bwd_p = w_cur_p - w_tgt_p;   // backward distance mod 2^16

    always_comb begin
        w_new_i = w_cur_i;
        if (w_cur_i < w_tgt_i)
            w_new_i = (w_up_i <= r_s1_rate_i) ? w_tgt_i : w_cur_i + r_s1_rate_i;
        else if (w_cur_i > w_tgt_i)
            w_new_i = (w_dn_i <= r_s1_rate_i) ? w_tgt_i : w_cur_i - r_s1_rate_i;

        // Half-turn tie (0x8000) resolves forward.
        w_new_p = w_cur_p;
        if (w_fwd_p != 16'h0000) begin
            if (w_fwd_p <= 16'h8000)
                w_new_p = (w_fwd_p <= r_s1_rate_p) ? w_tgt_p : w_cur_p + r_s1_rate_p;
            else
                w_new_p = (w_bwd_p <= r_s1_rate_p) ? w_tgt_p : w_cur_p - r_s1_rate_p;
        end

        if (r_s1_force) begin
            w_new_i = w_tgt_i;
            w_new_p = w_tgt_p;
        end
    end

    assign w_new = {w_new_i, w_new_p};

    // State memory has no reset; INIT clears it after every reset instead.
    always_ff @(posedge CLK) begin
        if (r_state == ST_INIT)
            r_mem[r_init_addr] <= 32'h0;
        else if (r_vld_pipe[2])
            r_mem[r_s2_idx] <= r_s2_new;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_INIT;
            r_init_addr <= 8'h00;
            r_idx       <= 8'h00;
            r_vld_pipe  <= '0;
            r_s1_idx    <= 8'h00;
            r_s1_cur    <= 32'h0;
            r_s1_tgt_i  <= 8'h00;
            r_s1_tgt_p  <= 8'h00;
            r_s1_rate_i <= 16'h0;
            r_s1_rate_p <= 16'h0;
            r_s1_force  <= 1'b0;
            r_s2_idx    <= 8'h00;
            r_s2_new    <= 32'h0;
            r_int_out   <= 8'h00;
            r_ph_out    <= 8'h00;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_addr <= r_init_addr + 8'd1;
                if (r_init_addr == LAST) r_state <= ST_RUN;
            end

            r_vld_pipe <= {r_vld_pipe[2:1], w_accept};

            if (w_accept) begin
                r_idx       <= (r_idx == LAST) ? 8'h00 : r_idx + 8'd1;
                r_s1_idx    <= r_idx;
                r_s1_cur    <= w_rd;
                r_s1_tgt_i  <= bus.INTENSITY;
                r_s1_tgt_p  <= bus.PHASE;
                r_s1_rate_i <= bus.UPDATE_RATE_INTENSITY;
                r_s1_rate_p <= bus.UPDATE_RATE_PHASE;
                r_s1_force  <= w_force;
            end

            if (r_vld_pipe[1]) begin
                r_s2_idx <= r_s1_idx;
                r_s2_new <= w_new;
            end

            if (r_vld_pipe[2]) begin
                r_int_out <= r_s2_new[31:24];
                r_ph_out  <= r_s2_new[15:8];
            end
        end
    end

    assign bus.INTENSITY_OUT = r_int_out;
    assign bus.PHASE_OUT     = r_ph_out;
    assign bus.DOUT_VALID    = r_vld_pipe[3];
    assign bus.BUSY          = (r_state == ST_INIT);
endmodule

// File: tb/tb_silent_step_applier.sv
// tb_silent_step_applier: drives full frames of beats, pushes expected outputs
// into a queue at drive time and compares them as DOUT_VALID pulses appear.
// Fixed indices 0..4 carry hand-derived sequences; the rest use a small model.
module tb_silent_step_applier;
    localparam int DEPTH = 249;
    localparam int NF    = 257;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    silent_step_if bus();

    silent_step_applier #(.DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] ei;
        logic [7:0] ep;
        int         stamp;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] m_ci [DEPTH];
    logic [15:0] m_cp [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [15:0] m_int(input logic [15:0] cur, input logic [15:0] tgt,
                                          input logic [15:0] r);
        int c = int'(cur);
        int t = int'(tgt);
        int rr = int'(r);
        if (t > c) return (t - c <= rr) ? tgt : 16'(c + rr);
        if (t < c) return (c - t <= rr) ? tgt : 16'(c - rr);
        return cur;
    endfunction

    function automatic logic [15:0] m_ph(input logic [15:0] cur, input logic [15:0] tgt,
                                         input logic [15:0] r);
        int c = int'(cur);
        int rr = int'(r);
        int d = (int'(tgt) - c + 65536) % 65536;
        if (d == 0) return cur;
        if (d <= 32768) return (d <= rr) ? tgt : 16'((c + rr) % 65536);
        return ((65536 - d) <= rr) ? tgt : 16'((c - rr + 65536) % 65536);
    endfunction

    function automatic logic [15:0] rand_rate();
        case ($urandom_range(3))
            0:       return 16'h0000;
            1:       return 16'($urandom_range(1, 16'h0300));
            2:       return 16'($urandom);
            default: return 16'hFFFF;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.DOUT_VALID) begin
            if (sbq.size() == 0) chk("spurious_dout", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("intensity_out", bus.INTENSITY_OUT, e.ei);
                chk("phase_out", bus.PHASE_OUT, e.ep);
                chk("latency", cyc - e.stamp, 3);
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_ci[i] = 16'h0;
            m_cp[i] = 16'h0;
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", bus.BUSY, 1);
        chk("rst_dout_valid", bus.DOUT_VALID, 0);
        chk("rst_intensity_out", bus.INTENSITY_OUT, 0);
        chk("rst_phase_out", bus.PHASE_OUT, 0);
    endtask

    // Release reset with DIN_VALID held high on junk; none of it may be taken.
    task automatic release_and_init();
        int cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.DIN_VALID = 1'b1;
        while (bus.BUSY && cnt < 1000) begin
            bus.INTENSITY = 8'($urandom);
            bus.PHASE     = 8'($urandom);
            @(posedge clk); #1;
            cnt++;
        end
        chk("init_busy_cycles", cnt, DEPTH);
    endtask

    task automatic drive_beat(input int f, input int i);
        logic [7:0]  ti = 8'($urandom);
        logic [7:0]  tp = 8'($urandom);
        logic [15:0] ri = rand_rate();
        logic [15:0] rp = rand_rate();
        logic        frc = 1'b0;
        logic        ci = 1'b0;
        logic        cp = 1'b0;
        logic [7:0]  ei = 8'h00;
        logic [7:0]  ep = 8'h00;
        logic [15:0] ni, np;
        exp_t        e;
`ifdef SILENT_FORCE_EN
        frc = ($urandom_range(7) == 0);
`endif
        case (i)
            0: begin  // intensity ramp 1..255 then hold
                ti = 8'hFF; ri = 16'h0100; tp = 8'h00; rp = 16'h0;
                frc = 1'b0; ci = 1'b1; cp = 1'b1;
                ei = (f < 255) ? 8'(f + 1) : 8'hFF; ep = 8'h00;
            end
            1: begin  // phase 0x0A00 -> 0xF000 backward
                ti = 8'h00; ri = 16'h0; frc = 1'b0; ci = 1'b1; cp = 1'b1; ei = 8'h00;
                if (f == 0) begin tp = 8'h0A; rp = 16'h0A00; ep = 8'h0A; end
                else begin
                    tp = 8'hF0; rp = 16'h0800;
                    ep = (f == 1) ? 8'h02 : (f == 2) ? 8'hFA : (f == 3) ? 8'hF2 : 8'hF0;
                end
            end
            2: begin  // half-turn tie goes forward
                ti = 8'h00; ri = 16'h0; tp = 8'h80; rp = 16'h4000;
                frc = 1'b0; ci = 1'b1; cp = 1'b1;
                ei = 8'h00; ep = (f == 0) ? 8'h40 : 8'h80;
            end
            3: begin  // rate 0 freezes after a changed target
                frc = 1'b0; ci = 1'b1; cp = 1'b1; ei = 8'h40; ep = 8'h33;
                if (f == 0) begin ti = 8'h40; ri = 16'h4000; tp = 8'h33; rp = 16'hFFFF; end
                else begin ti = 8'h10; ri = 16'h0; tp = 8'h99; rp = 16'h0; end
            end
            4: begin  // immediate jump when forced, otherwise rate 1
                ti = 8'hC8; ri = 16'h0001; tp = 8'h00; rp = 16'h0; frc = 1'b0;
`ifdef SILENT_FORCE_EN
                frc = (f == 0); ci = 1'b1; cp = 1'b1; ei = 8'hC8; ep = 8'h00;
`endif
            end
            default: ;
        endcase

        ni = frc ? {ti, 8'h00} : m_int(m_ci[i], {ti, 8'h00}, ri);
        np = frc ? {tp, 8'h00} : m_ph(m_cp[i], {tp, 8'h00}, rp);
        m_ci[i] = ni;
        m_cp[i] = np;
        if (!ci) ei = ni[15:8];
        if (!cp) ep = np[15:8];

        bus.DIN_VALID             = 1'b1;
        bus.INTENSITY             = ti;
        bus.PHASE                 = tp;
        bus.UPDATE_RATE_INTENSITY = ri;
        bus.UPDATE_RATE_PHASE     = rp;
`ifdef SILENT_FORCE_EN
        bus.FORCE                 = frc;
`endif
        e.ei = ei; e.ep = ep; e.stamp = cyc;
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async_dout_valid", bus.DOUT_VALID, 0);
        sbq.delete();
        model_clear();
        bus.DIN_VALID = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        release_and_init();
    endtask

    task automatic run_frame(input int f, input int abort_at);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            if ($urandom_range(31) == 0) begin
                bus.DIN_VALID = 1'b0;
                @(posedge clk); #1;
            end
            drive_beat(f, i);
        end
        bus.DIN_VALID = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.DIN_VALID             = 1'b0;
        bus.INTENSITY             = 8'h00;
        bus.PHASE                 = 8'h00;
        bus.UPDATE_RATE_INTENSITY = 16'h0;
        bus.UPDATE_RATE_PHASE     = 16'h0;
`ifdef SILENT_FORCE_EN
        bus.FORCE                 = 1'b0;
`endif
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        release_and_init();

        for (int f = 0; f < NF; f++) run_frame(f, -1);
        // Reset in the middle of a frame, then restart the fixed sequences from 0.
        run_frame(NF, 100);
        for (int f = 0; f < 2; f++) run_frame(f, -1);

        bus.DIN_VALID = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_pending", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
